run_control: RTL and testbench

//  Parametrised CPU run/step/breakpoint controller; successor of the fixed single-breakpoint clock block.

---
 rtl/run_control_pkg.sv | 16 +
 rtl/btn_debounce.sv | 47 ++++
 rtl/run_control.sv | 145 ++++++++++++++
 tb/tb_run_control.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_control_pkg.sv
// Shared types and helpers for the CPU run/step/breakpoint controller.
package run_control_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    CYCLE = 2'd2,
    INSTR = 2'd3
  } state_t;

  // Index/counter width that never collapses to zero bits for a value of 1.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises a raw push button, debounces it and flags its rising edge.
module btn_debounce
  import run_control_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int                CNT_W    = clog2_min1(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  // NOTE: level restarts as "pressed", so a press held through reset has to be
  // released and debounced low before any rising edge can be reported.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync    <= '0;
      cnt     <= '0;
      o_level <= 1'b1;
      o_rise  <= 1'b0;
    end else begin
      sync   <= SYNC_STAGES'({sync, i_btn});
      o_rise <= 1'b0;
      if (synced == o_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        o_level <= synced;
        o_rise  <= synced;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/run_control.sv
// CPU clock-enable controller: free run at a divided rate, single cycle or
// single instruction stepping, and BP_COUNT PC breakpoints.
module run_control
  import run_control_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int BP_COUNT        = 4,
  parameter int CLK_DIV         = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_btnStep,
  input  logic                           i_swInstrNCycle,
  input  logic                           i_swStepNRun,
  input  logic                           i_ctrlInstrFinishedN,
  input  logic [ADDR_WIDTH-1:0]          i_pc,
  input  logic [BP_COUNT*ADDR_WIDTH-1:0] i_bpAddress,
  input  logic [BP_COUNT-1:0]            i_bpEnable,
  output logic                           o_cpuClkEn,
  output logic                           o_halt,
  output logic                           o_instrStart,
  output logic                           o_bpHit,
  output logic [clog2_min1(BP_COUNT)-1:0] o_bpIndex
);

  localparam int IDX_W = clog2_min1(BP_COUNT);
  localparam int DIV_W = clog2_min1(CLK_DIV);

  state_t           state;
  logic             mask;
  logic             btn_level;
  logic             btn_rise;
  logic             step_req;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             bp_match;
  logic [IDX_W-1:0] bp_idx;
  logic             bp_fire;
  logic             boundary;

  btn_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_btn  (i_btnStep),
    .o_level(btn_level),
    .o_rise (btn_rise)
  );

  assign step_req = btn_rise & btn_level;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) div_cnt <= '0;
    else         div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  // NOTE: defaults before the loop keep this purely combinational (no latches);
  // scanning downwards lets the lowest matching index win.
  always_comb begin
    bp_match = 1'b0;
    bp_idx   = '0;
    for (int k = BP_COUNT - 1; k >= 0; k--) begin
      if (i_bpEnable[k] && (i_pc == i_bpAddress[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
        bp_match = 1'b1;
        bp_idx   = IDX_W'(k);
      end
    end
  end

  assign bp_fire  = o_instrStart && !mask && bp_match;
  assign boundary = !i_ctrlInstrFinishedN;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= HALT;
      mask         <= 1'b0;
      o_cpuClkEn   <= 1'b0;
      o_halt       <= 1'b1;
      o_instrStart <= 1'b1;
      o_bpHit      <= 1'b0;
      o_bpIndex    <= '0;
    end else begin
      o_cpuClkEn <= 1'b0;
      unique case (state)
        HALT: begin
          if (step_req && i_swStepNRun) begin
            state  <= i_swInstrNCycle ? INSTR : CYCLE;
            o_halt <= 1'b0;
          end else if (!i_swStepNRun && !o_bpHit) begin
            state  <= RUN;
            o_halt <= 1'b0;
          end else if (step_req && !i_swStepNRun) begin
            // Resume from a breakpoint: skip the check once so we step past it.
            o_bpHit <= 1'b0;
            mask    <= 1'b1;
            state   <= RUN;
            o_halt  <= 1'b0;
          end
        end
        RUN: begin
          if (tick) begin
            if (bp_fire) begin
              state     <= HALT;
              o_halt    <= 1'b1;
              o_bpHit   <= 1'b1;
              o_bpIndex <= bp_idx;
            end else begin
              o_cpuClkEn   <= 1'b1;
              o_instrStart <= boundary;
              mask         <= 1'b0;
              if (boundary && i_swStepNRun) begin
                state  <= HALT;
                o_halt <= 1'b1;
              end
            end
          end
        end
        CYCLE: begin
          if (tick) begin
            o_cpuClkEn   <= 1'b1;
            o_instrStart <= boundary;
            state        <= HALT;
            o_halt       <= 1'b1;
          end
        end
        INSTR: begin
          if (tick) begin
            o_cpuClkEn   <= 1'b1;
            o_instrStart <= boundary;
            if (boundary) begin
              state  <= HALT;
              o_halt <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control with a small CPU model and an expected-PC
// scoreboard consumed on every issued clock enable.
module tb_run_control;

  localparam int AW  = 16;
  localparam int BPC = 4;
  localparam int DIV = 4;
  localparam int DEB = 8;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_btnStep;
  logic              i_swInstrNCycle;
  logic              i_swStepNRun;
  logic              i_ctrlInstrFinishedN;
  logic [AW-1:0]     i_pc;
  logic [BPC*AW-1:0] i_bpAddress;
  logic [BPC-1:0]    i_bpEnable;
  logic              o_cpuClkEn;
  logic              o_halt;
  logic              o_instrStart;
  logic              o_bpHit;
  logic [1:0]        o_bpIndex;

  run_control #(
    .ADDR_WIDTH     (AW),
    .BP_COUNT       (BPC),
    .CLK_DIV        (DIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .i_clk               (i_clk),
    .i_reset             (i_reset),
    .i_btnStep           (i_btnStep),
    .i_swInstrNCycle     (i_swInstrNCycle),
    .i_swStepNRun        (i_swStepNRun),
    .i_ctrlInstrFinishedN(i_ctrlInstrFinishedN),
    .i_pc                (i_pc),
    .i_bpAddress         (i_bpAddress),
    .i_bpEnable          (i_bpEnable),
    .o_cpuClkEn          (o_cpuClkEn),
    .o_halt              (o_halt),
    .o_instrStart        (o_instrStart),
    .o_bpHit             (o_bpHit),
    .o_bpIndex           (o_bpIndex)
  );

  initial forever #5 i_clk = ~i_clk;

  int            n_cmp;
  int            n_fail;
  int            cyc_no;
  int            en_cnt;
  int            rises;
  int            en_t[$];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] cpu_pc;
  int            cpu_cyc;
  int            ilen;
  logic          loop_en;
  logic [AW-1:0] loop_lo;
  logic [AW-1:0] loop_hi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_cpu();
    i_pc                 = cpu_pc;
    i_ctrlInstrFinishedN = (cpu_cyc != ilen - 1);
  endtask

  // One clock: sample at the falling edge, retire enables against the scoreboard,
  // then advance the CPU model and redrive its outputs.
  task automatic tick1();
    logic [AW-1:0] want;
    @(negedge i_clk);
    cyc_no++;
    if (dut.u_btn.o_rise) rises++;
    if (i_reset) begin
      cpu_cyc = 0;
    end else if (o_cpuClkEn) begin
      en_cnt++;
      en_t.push_back(cyc_no);
      check("enable_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check("enable_pc", cpu_pc, want);
      end
      if (cpu_cyc == ilen - 1) begin
        cpu_cyc = 0;
        if (loop_en && cpu_pc == loop_hi) cpu_pc = loop_lo;
        else                              cpu_pc = cpu_pc + 1'b1;
      end else begin
        cpu_cyc++;
      end
    end
    drive_cpu();
  endtask

  task automatic press();
    i_btnStep = 1'b1;
    repeat (12) tick1();
    i_btnStep = 1'b0;
  endtask

  task automatic wait_halt(input logic level, input int budget, input string tag);
    for (int i = 0; i < budget && o_halt !== level; i++) tick1();
    check(tag, o_halt, level);
  endtask

  task automatic push_pairs(input logic [AW-1:0] first, input int count);
    for (int i = 0; i < count; i++) begin
      exp_q.push_back(first + AW'(i));
      exp_q.push_back(first + AW'(i));
    end
  endtask

  int rises0;
  int en0;

  initial begin
    n_cmp = 0; n_fail = 0; cyc_no = 0; en_cnt = 0; rises = 0;
    i_reset = 1'b0; i_btnStep = 1'b0; i_swInstrNCycle = 1'b0; i_swStepNRun = 1'b1;
    i_bpAddress = '0; i_bpEnable = '0;
    ilen = 1; cpu_pc = 16'h0100; cpu_cyc = 0; loop_en = 1'b0; loop_lo = '0; loop_hi = '0;
    drive_cpu();

    // Reset values, applied asynchronously before any clock edge.
    #2 i_reset = 1'b1;
    #1;
    check("rst_cpuClkEn", o_cpuClkEn, 1'b0);
    check("rst_halt", o_halt, 1'b1);
    check("rst_instrStart", o_instrStart, 1'b1);
    check("rst_bpHit", o_bpHit, 1'b0);
    check("rst_bpIndex", o_bpIndex, 2'd0);
    repeat (3) tick1();
    i_reset = 1'b0;
    repeat (16) tick1();
    check("idle_halt", o_halt, 1'b1);

    // 1: bouncing button in cycle-step mode yields a single step.
    rises0 = rises; en0 = en_cnt;
    exp_q.push_back(16'h0100);
    for (int i = 0; i < 40; i++) begin
      i_btnStep = ((i / 3) % 2) == 1;
      tick1();
    end
    press();
    repeat (20) tick1();
    check("t1_step_requests", rises - rises0, 1);
    check("t1_enables", en_cnt - en0, 1);
    check("t1_halt", o_halt, 1'b1);
    check("t1_instrStart", o_instrStart, 1'b1);

    // 2: instruction step over a three-cycle instruction.
    ilen = 3; i_swInstrNCycle = 1'b1; drive_cpu();
    en_t.delete(); en0 = en_cnt;
    repeat (3) exp_q.push_back(16'h0101);
    press();
    repeat (30) tick1();
    check("t2_enables", en_cnt - en0, 3);
    if (en_t.size() >= 3) begin
      check("t2_spacing_a", en_t[1] - en_t[0], DIV);
      check("t2_spacing_b", en_t[2] - en_t[1], DIV);
    end
    check("t2_halt", o_halt, 1'b1);
    check("t2_instrStart", o_instrStart, 1'b1);
    check("t2_queue_drained", exp_q.size(), 0);

    // 3: run into bp2 at 0x0010; disabled bp0 at the same address must not win.
    i_bpAddress = {16'h0030, 16'h0010, 16'h000D, 16'h0010};
    i_bpEnable  = 4'b0100;
    ilen = 2; cpu_pc = 16'h000C; cpu_cyc = 0; drive_cpu();
    push_pairs(16'h000C, 4);
    i_swStepNRun = 1'b0;
    wait_halt(1'b0, 10, "t3_running");
    wait_halt(1'b1, 100, "t3_halted");
    check("t3_bpHit", o_bpHit, 1'b1);
    check("t3_bpIndex", o_bpIndex, 2'd2);
    check("t3_pc", i_pc, 16'h0010);
    check("t3_queue_drained", exp_q.size(), 0);
    repeat (12) tick1();
    check("t3_still_halted", o_halt, 1'b1);

    // 4: resume steps past 0x0010, then re-hits when the program loops back.
    loop_en = 1'b1; loop_hi = 16'h0012; loop_lo = 16'h000F;
    push_pairs(16'h0010, 3);
    push_pairs(16'h000F, 1);
    press();
    wait_halt(1'b0, 10, "t4_resumed");
    check("t4_bpHit_cleared", o_bpHit, 1'b0);
    wait_halt(1'b1, 100, "t4_rehit");
    check("t4_bpHit", o_bpHit, 1'b1);
    check("t4_bpIndex", o_bpIndex, 2'd2);
    check("t4_pc", i_pc, 16'h0010);
    check("t4_queue_drained", exp_q.size(), 0);

    // 5: bp0 and bp3 share 0x0020; lowest enabled index wins.
    loop_en = 1'b0;
    i_bpAddress = {16'h0020, 16'h0010, 16'h0010, 16'h0020};
    i_bpEnable  = 4'b1001;
    cpu_pc = 16'h001E; cpu_cyc = 0; drive_cpu();
    push_pairs(16'h001E, 2);
    press();
    wait_halt(1'b0, 10, "t5a_resumed");
    wait_halt(1'b1, 100, "t5a_halted");
    check("t5a_bpIndex", o_bpIndex, 2'd0);
    check("t5a_pc", i_pc, 16'h0020);

    i_bpEnable = 4'b1000;
    cpu_pc = 16'h001E; cpu_cyc = 0; drive_cpu();
    push_pairs(16'h001E, 2);
    press();
    wait_halt(1'b0, 10, "t5b_resumed");
    wait_halt(1'b1, 100, "t5b_halted");
    check("t5b_bpIndex", o_bpIndex, 2'd3);
    check("t5b_pc", i_pc, 16'h0020);
    check("t5b_queue_drained", exp_q.size(), 0);

    i_bpEnable = 4'b0000;
    cpu_pc = 16'h001E; cpu_cyc = 0; drive_cpu();
    push_pairs(16'h001E, 34);
    press();
    wait_halt(1'b0, 10, "t5c_resumed");
    repeat (80) tick1();
    check("t5c_never_halts", o_halt, 1'b0);
    check("t5c_no_bpHit", o_bpHit, 1'b0);
    i_swStepNRun = 1'b1;
    wait_halt(1'b1, 20, "t5c_switch_halt");
    check("t5c_boundary", cpu_cyc, 0);
    check("t5c_instrStart", o_instrStart, 1'b1);
    exp_q.delete();

    // 6: reset during an instruction step with a press still debouncing.
    ilen = 3; cpu_cyc = 0; i_swInstrNCycle = 1'b1; drive_cpu();
    exp_q.push_back(cpu_pc);
    en0 = en_cnt;
    press();
    for (int i = 0; i < 20 && en_cnt == en0; i++) tick1();
    check("t6_first_enable", en_cnt - en0, 1);
    i_btnStep = 1'b1;
    repeat (2) tick1();
    check("t6_mid_instr", o_halt, 1'b0);
    i_reset = 1'b1;
    #1;
    check("t6_rst_cpuClkEn", o_cpuClkEn, 1'b0);
    check("t6_rst_halt", o_halt, 1'b1);
    check("t6_rst_instrStart", o_instrStart, 1'b1);
    check("t6_rst_bpHit", o_bpHit, 1'b0);
    check("t6_rst_bpIndex", o_bpIndex, 2'd0);
    rises0 = rises; en0 = en_cnt;
    repeat (3) tick1();
    i_reset = 1'b0;
    repeat (6) tick1();
    i_btnStep = 1'b0;
    repeat (30) tick1();
    check("t6_no_step_req", rises - rises0, 0);
    check("t6_no_enable", en_cnt - en0, 0);
    check("t6_halt", o_halt, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
